// File: rtl/envelope_peak_detector.sv
// envelope_peak_detector
//   Rectifies signed 12-bit receive-coil samples and publishes the peak
//   magnitude of each WINDOW_LEN-sample window. After i_enable rises, the
//   first SETTLE_LEN valid samples are discarded.
//   Optional feature macro: ENVELOPE_AVG_EN. When it is defined, each publish
//   averages the new peak with the previously published value.
//
// Sample qualifier semantics: i_sample is consumed on every rising edge where
// i_sample_valid=1, i_enable=1 and the FSM is already in SETTLE or ACQUIRE.
// There is no back-pressure, so the block accepts every qualified sample.
// o_max_valid is a one-cycle strobe. o_envelope_max changes only in that
// cycle and holds its value otherwise.

module envelope_peak_detector #(
  parameter int WINDOW_LEN = 1000,
  parameter int SETTLE_LEN = 256
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_enable,
  input  logic               i_sample_valid,
  input  logic signed [11:0] i_sample,
  output logic signed [11:0] o_envelope_max,
  output logic               o_max_valid,
  output logic [1:0]         o_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] ACQUIRE = 2'd2;

  // Terminal counts. The counter is compared against N-1, so it never wraps.
  // When SETTLE_LEN is 0, SETTLE_LAST is unused because SETTLE is skipped.
  localparam logic [15:0] WIN_LAST    = 16'(WINDOW_LEN - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_LEN - 1);

  logic [1:0]  state_q,   state_d;
  logic [15:0] cnt_q,     cnt_d;
  logic [11:0] run_max_q, run_max_d;
  logic [11:0] env_q,     env_d;
  logic        vld_q,     vld_d;

  logic [11:0] mag;
  logic [11:0] peak;
  logic [11:0] pub_val;

`ifdef ENVELOPE_AVG_EN
  // Set when no publish has happened since reset or since IDLE.
  // The next publish then averages the peak with itself.
  logic        first_q, first_d;
  logic [11:0] prev;
  logic [12:0] sum13;
`endif

  // Magnitude of the incoming sample. -2048 has no positive twin,
  // so it saturates to 2047.
  always_comb begin
    mag = 12'd0;
    if (i_sample == -12'sd2048) begin
      mag = 12'd2047;
    end else if (i_sample[11]) begin
      mag = 12'(-i_sample);
    end else begin
      mag = 12'(i_sample);
    end
  end

  // Window peak including the current sample, and the value to publish.
  always_comb begin
    peak = (mag > run_max_q) ? mag : run_max_q;
`ifdef ENVELOPE_AVG_EN
    prev    = first_q ? peak : env_q;
    sum13   = {1'b0, prev} + {1'b0, peak};
    pub_val = sum13[12:1];
`else
    pub_val = peak;
`endif
  end

  // Next-state logic. An enable drop overrides everything else,
  // including a window-completing sample in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    env_d     = env_q;
    vld_d     = 1'b0;
`ifdef ENVELOPE_AVG_EN
    first_d   = first_q;
`endif
    if (!i_enable) begin
      state_d   = IDLE;
      cnt_d     = 16'd0;
      run_max_d = 12'd0;
`ifdef ENVELOPE_AVG_EN
      first_d   = 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = (SETTLE_LEN == 0) ? ACQUIRE : SETTLE;
          cnt_d     = 16'd0;
          run_max_d = 12'd0;
        end
        SETTLE: begin
          if (i_sample_valid) begin
            if (cnt_q == SETTLE_LAST) begin
              cnt_d   = 16'd0;
              state_d = ACQUIRE;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        ACQUIRE: begin
          if (i_sample_valid) begin
            if (cnt_q == WIN_LAST) begin
              env_d     = pub_val;
              vld_d     = 1'b1;
              run_max_d = 12'd0;
              cnt_d     = 16'd0;
`ifdef ENVELOPE_AVG_EN
              first_d   = 1'b0;
`endif
            end else begin
              run_max_d = peak;
              cnt_d     = cnt_q + 16'd1;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_d     = 16'd0;
          run_max_d = 12'd0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      run_max_q <= 12'd0;
      env_q     <= 12'd0;
      vld_q     <= 1'b0;
`ifdef ENVELOPE_AVG_EN
      first_q   <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      env_q     <= env_d;
      vld_q     <= vld_d;
`ifdef ENVELOPE_AVG_EN
      first_q   <= first_d;
`endif
    end
  end

  assign o_envelope_max = $signed(env_q);
  assign o_max_valid    = vld_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_envelope_peak_detector.sv
// tb_envelope_peak_detector
//   Drives two detectors with a shared stimulus stream. Both use
//   WINDOW_LEN=4; dut_a has SETTLE_LEN=0 and dut_b has SETTLE_LEN=2.
//   Expected behaviour comes from a queue-based window model. Directed
//   scenarios are followed by randomized traffic. ENVELOPE_AVG_EN is
//   honoured when defined.

module tb_envelope_peak_detector;

  localparam int WL   = 4;
  localparam int SL_A = 0;
  localparam int SL_B = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               nrst = 1'b0;
  logic               en   = 1'b0;
  logic               sv   = 1'b0;
  logic signed [11:0] smp  = 12'sd0;

  logic signed [11:0] env_a, env_b;
  logic               vld_a, vld_b;
  logic [1:0]         st_a, st_b;

  envelope_peak_detector #(.WINDOW_LEN(WL), .SETTLE_LEN(SL_A)) dut_a (
    .i_clk(clk), .i_nrst(nrst), .i_enable(en), .i_sample_valid(sv),
    .i_sample(smp), .o_envelope_max(env_a), .o_max_valid(vld_a), .o_state(st_a)
  );

  envelope_peak_detector #(.WINDOW_LEN(WL), .SETTLE_LEN(SL_B)) dut_b (
    .i_clk(clk), .i_nrst(nrst), .i_enable(en), .i_sample_valid(sv),
    .i_sample(smp), .o_envelope_max(env_b), .o_max_valid(vld_b), .o_state(st_b)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];          // publishes expected from dut_a, in order

  // ---------------- reference model ----------------
  bit armed[2];
  int settle_left[2];
  bit first[2];
  int m_env[2];
  bit m_vld[2];
  int q_a[$];
  int q_b[$];

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rect(input logic signed [11:0] s);
    int v;
    v = s;
    if (v < 0) v = -v;
    if (v > 2047) v = 2047;
    return v;
  endfunction

  // Predicts the outputs that follow the next rising edge (or an
  // asynchronous reset) for both DUTs.
  task automatic model_edge(input bit n, input bit e, input bit v, input logic signed [11:0] s);
    int peak, prev, sz;
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 1'b0;
      if (!n || !e) begin
        armed[k] = 1'b0;
        first[k] = 1'b1;
        if (k == 0) q_a.delete(); else q_b.delete();
        if (!n) m_env[k] = 0;
      end else if (!armed[k]) begin
        armed[k] = 1'b1;
        settle_left[k] = (k == 0) ? SL_A : SL_B;
      end else if (v) begin
        if (settle_left[k] > 0) begin
          settle_left[k]--;
        end else begin
          if (k == 0) q_a.push_back(rect(s)); else q_b.push_back(rect(s));
          sz = (k == 0) ? q_a.size() : q_b.size();
          if (sz == WL) begin
            peak = 0;
            for (int i = 0; i < WL; i++) begin
              if (k == 0 && q_a[i] > peak) peak = q_a[i];
              if (k == 1 && q_b[i] > peak) peak = q_b[i];
            end
`ifdef ENVELOPE_AVG_EN
            prev     = first[k] ? peak : m_env[k];
            m_env[k] = (prev + peak) / 2;
`else
            prev     = peak;
            m_env[k] = prev;
`endif
            first[k] = 1'b0;
            m_vld[k] = 1'b1;
            if (k == 0) begin
              q_a.delete();
              exp_q.push_back(12'(m_env[k]));
            end else begin
              q_b.delete();
            end
          end
        end
      end
    end
  endtask

  function automatic logic [1:0] exp_state(input int k);
    if (!armed[k]) return 2'd0;
    if (settle_left[k] > 0) return 2'd1;
    return 2'd2;
  endfunction

  task automatic check_outputs();
    check_val("env_a", 16'(env_a), 16'(m_env[0]));
    check_val("vld_a", 16'(vld_a), 16'(m_vld[0]));
    check_val("st_a",  16'(st_a),  16'(exp_state(0)));
    check_val("env_b", 16'(env_b), 16'(m_env[1]));
    check_val("vld_b", 16'(vld_b), 16'(m_vld[1]));
    check_val("st_b",  16'(st_b),  16'(exp_state(1)));
    if (vld_a === 1'b1) begin
      if (exp_q.size() == 0) check_val("pub_a_unexpected", 16'(env_a), 16'hFFFF);
      else check_val("pub_a", 16'(env_a), 16'(exp_q.pop_front()));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge. Drives one cycle of inputs, then checks
  // #1 after the following edge.
  task automatic step(input bit e, input bit v, input logic signed [11:0] s);
    en  = e;
    sv  = v;
    smp = s;
    model_edge(nrst, e, v, s);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic window(input logic signed [11:0] s0, input logic signed [11:0] s1,
                        input logic signed [11:0] s2, input logic signed [11:0] s3);
    step(1, 1, s0);
    step(1, 1, s1);
    step(1, 1, s2);
    step(1, 1, s3);
  endtask

  task automatic async_reset();
    nrst = 1'b0;
    #2;
    model_edge(1'b0, en, sv, smp);
    check_outputs();
    check_val("rst_env_a", 16'(env_a), 16'd0);
    check_val("rst_vld_a", 16'(vld_a), 16'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [11:0] held;

  initial begin
    for (int k = 0; k < 2; k++) begin
      armed[k] = 0; settle_left[k] = 0; first[k] = 1; m_env[k] = 0; m_vld[k] = 0;
    end
    // Reset state
    #2;
    model_edge(1'b0, 1'b0, 1'b0, 12'sd0);
    check_outputs();
    @(posedge clk); #1;
    nrst = 1'b1;
    step(0, 0, 12'sd0);

    // Basic window: 10,-300,50,20 publishes 300 one cycle after the 4th sample
    step(1, 0, 12'sd0);
    window(12'sd10, -12'sd300, 12'sd50, 12'sd20);
    check_val("r026_vld", 16'(vld_a), 16'd1);
    check_val("r026_env", 16'(env_a), 16'd300);

    // Asynchronous reset mid-window clears outputs immediately
    step(1, 1, 12'sd5);
    step(1, 1, 12'sd5);
    async_reset();
    step(1, 0, 12'sd0);              // reset still low across an edge
    nrst = 1'b1;
    step(1, 0, 12'sd0);              // first edge after release arms the FSM
    window(12'sd7, 12'sd1, 12'sd2, 12'sd3);
    check_val("r030_env", 16'(env_a), 16'd7);

    // -2048 saturates to 2047
    step(0, 1, 12'sd0);
    step(1, 0, 12'sd0);
    window(12'sd0, -12'sd2048, 12'sd0, 12'sd0);
    check_val("r027_env", 16'(env_a), 16'd2047);

    // Consecutive windows 400 then 200
    step(0, 0, 12'sd0);
    step(1, 0, 12'sd0);
    window(12'sd400, 12'sd1, 12'sd2, 12'sd3);
    check_val("r031_first", 16'(env_a), 16'd400);
    window(-12'sd200, 12'sd0, 12'sd0, 12'sd0);
`ifdef ENVELOPE_AVG_EN
    check_val("r031_second", 16'(env_a), 16'd300);
`else
    check_val("r031_second", 16'(env_a), 16'd200);
`endif

    // Settle samples are ignored by dut_b
    step(0, 0, 12'sd0);
    step(1, 0, 12'sd0);
    window(12'sd900, 12'sd900, 12'sd5, 12'sd6);
    step(1, 1, 12'sd7);
    step(1, 1, 12'sd8);
    check_val("r028_vld_b", 16'(vld_b), 16'd1);
    check_val("r028_env_b", 16'(env_b), 16'd8);

    // Enable drop discards a partial window; held value persists
    held = 12'(env_a);
    step(0, 1, 12'sd0);
    step(1, 0, 12'sd0);
    step(1, 1, 12'sd40);
    step(1, 1, 12'sd40);
    step(1, 1, 12'sd40);
    step(0, 1, 12'sd40);             // 4th sample lands with enable low: dropped
    check_val("r029_hold", 16'(env_a), 16'(held));
    check_val("r029_novld", 16'(vld_a), 16'd0);
    step(0, 1, 12'sd99);
    step(1, 0, 12'sd0);
    window(12'sd40, 12'sd40, 12'sd40, 12'sd40);
    check_val("r029_env", 16'(env_a), 16'd40);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic signed [11:0] s;
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)      s = -12'sd2048;
      else if (r == 1) s = 12'sd2047;
      else             s = 12'($urandom_range(0, 4095));
      if (i == 1000) begin
        async_reset();
        step(1, 1, s);
        nrst = 1'b1;
      end
      step($urandom_range(0, 99) < 96, $urandom_range(0, 9) < 7, s);
    end

    check_val("pub_a_left", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/envelope_peak_detector.md
ENVELOPE_PEAK_DETECTOR -- requirements
Module: envelope_peak_detector

Interface
REQ-001 Parameter WINDOW_LEN, default 1000: number of accepted samples per peak window; legal range 2..65535.
REQ-002 Parameter SETTLE_LEN, default 256: number of samples discarded after enable rises; legal range 0..65535.
REQ-003 i_clk  input  1  system clock; all logic on rising edge.
REQ-004 i_nrst  input  1  reset, asynchronous, active-low.
REQ-005 i_enable  input  1  measurement enable; driven by the frequency tracker's o_enable.
REQ-006 i_sample_valid  input  1  one-cycle qualifier for i_sample.
REQ-007 i_sample  input  12  signed two's-complement ADC sample of the receive-coil voltage.
REQ-008 o_envelope_max  output  12  signed, always >= 0; last published window peak; feeds the tracker's i_envelope_max.
REQ-009 o_max_valid  output  1  one-cycle pulse when o_envelope_max updates.
REQ-010 o_state  output  2  debug: current FSM state encoding.

Function
REQ-011 The block SHALL rectify each accepted sample: mag = |i_sample|, with -2048 saturating to 2047.
REQ-012 The block SHALL implement FSM states IDLE=0, SETTLE=1, ACQUIRE=2.
REQ-013 IDLE: while i_enable=0, sample_cnt=0 and run_max=0; on i_enable=1, go to SETTLE, or to ACQUIRE directly if SETTLE_LEN=0.
REQ-014 SETTLE: each valid sample increments sample_cnt without updating run_max; on the SETTLE_LEN-th valid sample, clear sample_cnt and go to ACQUIRE.
REQ-015 ACQUIRE: each valid sample updates run_max to max(run_max, mag) and increments sample_cnt.
REQ-016 On the WINDOW_LEN-th valid sample in ACQUIRE, the block SHALL, on the next clock edge:
  - load o_envelope_max with max(run_max, mag of that sample);
  - pulse o_max_valid high for exactly one cycle;
  - clear run_max and sample_cnt;
  - remain in ACQUIRE.
  Latency from last sample to o_max_valid is 1 cycle.
REQ-017 The first valid sample after a window boundary SHALL count as sample 1 of the new window, with no lost sample.
REQ-018 Cycles with i_sample_valid=0 SHALL change nothing except i_enable handling.
REQ-019 i_enable falling in any state SHALL return the FSM to IDLE next cycle and discard the partial window; o_envelope_max holds its last value and o_max_valid stays 0.
REQ-020 If i_enable falls in the same cycle as a window-completing sample, the enable drop wins: no publish, IDLE.
REQ-021 sample_cnt SHALL be 16 bits unsigned; comparisons use WINDOW_LEN-1 and SETTLE_LEN-1 so no wrap occurs.
REQ-022 o_envelope_max SHALL never be negative and SHALL change only on an o_max_valid cycle.

Reset
REQ-023 Asserting i_nrst=0 SHALL immediately force: state IDLE, sample_cnt=0, run_max=0, o_envelope_max=0, o_max_valid=0, averaging register=0.
REQ-024 Reset release mid-stream SHALL begin in IDLE; if i_enable=1, SETTLE starts on the first cycle after release.

Configuration
REQ-025 Macro ENVELOPE_AVG_EN selects how the window peak is published.
  - Defined: each publish loads o_envelope_max with (prev + peak) >> 1 using a 13-bit intermediate, where prev is the value before the update; the first publish after reset or after IDLE uses prev = peak.
  - Not defined: o_envelope_max equals the raw window peak.

Verification
REQ-026 WINDOW_LEN=4, SETTLE_LEN=0, enable=1, samples 10,-300,50,20 -> one cycle after the 4th sample, o_max_valid=1 and o_envelope_max=300.
REQ-027 Sample -2048 inside a window of zeros -> published peak 2047.
REQ-028 SETTLE_LEN=2, samples 900,900,5,6,7,8 (WINDOW_LEN=4) -> publish 8; the settle samples are ignored.
REQ-029 Enable drops after 3 of 4 samples, re-enables, then 4 samples of value 40 -> exactly one publish, of 40; the prior o_envelope_max is held during the gap.
REQ-030 i_nrst asserted mid-window with o_envelope_max=300 -> all outputs 0 asynchronously, and the next publish reflects only post-reset samples.
REQ-031 ENVELOPE_AVG_EN defined, consecutive window peaks 400 then 200 -> o_envelope_max 400, then 300.
